// File: rtl/toy_uart_rx_if.sv
// Byte delivery handshake between the UART receiver and its consumer.
// The receiver drives rx_data/rx_valid; the consumer answers with rx_ready.
interface toy_uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/toy_uart_rx.sv
// 8N1 UART receiver matching the toy MCU transmitter's BAUD_DIV timing.
// Bytes are delivered on a valid/ready handshake; framing and overrun are flagged as pulses.
module toy_uart_rx #(
  parameter int BAUD_DIV = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx,
  toy_uart_rx_if.master  bus,
  output logic           frame_err,
  output logic           overrun,
  output logic           busy
);

  localparam int HALF = (BAUD_DIV - 1) / 2;
  localparam int CW   = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          sync1;
  logic          sync2;
  logic          rxs;

  assign rxs  = sync2;
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      shreg        <= '0;
      sync1        <= 1'b1;
      sync2        <= 1'b1;
      bus.rx_data  <= '0;
      bus.rx_valid <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sync1     <= rx;
      sync2     <= sync1;
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      if (bus.rx_valid && bus.rx_ready)
        bus.rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= '0;
          end
        end

        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rxs) begin
              state <= DATA;
              idx   <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == CNT_LAST) begin
            shreg[idx] <= rxs;
            cnt        <= '0;
            idx        <= idx + 1'b1;
            if (idx == 3'd7)
              state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rxs) begin
              state <= IDLE;
              // A consume on the completion cycle frees the slot, so the new byte wins.
              if (!bus.rx_valid || bus.rx_ready) begin
                bus.rx_data  <= shreg;
                bus.rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HI;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WAIT_HI: begin
          if (rxs)
            state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
